// File: rtl/ps2_kbd_cmd_sequencer.sv
// ps2_kbd_cmd_sequencer: host-to-keyboard LED/reset command sequencer driving PS2_Controller's transmit side
// Ports:
//   CLOCK_50, reset                 clock, synchronous active-high reset
//   led_req, led_bits               LED update request pulse, {caps, num, scroll}
//   kbd_rst_req                     keyboard reset (0xFF) request pulse
//   received_data, received_data_en keyboard byte and its one-cycle valid
//   command_was_sent                transmitter finished the byte
//   error_communication_timed_out   transmitter gave up on the line
//   the_command, send_command       byte to send and held send request
//   rx_filter                       keyboard response expected; parser drops bytes
//   busy, done, err, err_code       status (err_code 1=line, 2=no response, 3=retries/BAT fail)
//   leds_applied                    last LED value the keyboard acknowledged
module ps2_kbd_cmd_sequencer #(
   parameter int ACK_TIMEOUT = 1000000,
   parameter int BAT_TIMEOUT = 50000000,
   parameter int MAX_RETRY   = 3
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic       led_req,
   input  logic [2:0] led_bits,
   input  logic       kbd_rst_req,
   input  logic [7:0] received_data,
   input  logic       received_data_en,
   input  logic       command_was_sent,
   input  logic       error_communication_timed_out,
   output logic [7:0] the_command,
   output logic       send_command,
   output logic       rx_filter,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic [1:0] err_code,
   output logic [2:0] leds_applied
);
   localparam int TW = $clog2(BAT_TIMEOUT > ACK_TIMEOUT ? BAT_TIMEOUT : ACK_TIMEOUT) + 1;
   localparam int RW = $clog2(MAX_RETRY + 1) + 1;
   localparam logic [TW-1:0] ACK_LAST  = TW'(ACK_TIMEOUT - 1);
   localparam logic [TW-1:0] BAT_LAST  = TW'(BAT_TIMEOUT - 1);
   localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
   typedef enum logic [2:0] {IDLE, SEND, WAIT_ACK, WAIT_BAT, DONE, FAIL} state_t;
   state_t        r_state, w_next;
   logic          r_led_pend, r_rst_pend, r_is_rst, r_idx;
   logic [2:0]    r_led_bits, r_snap;
   logic [RW-1:0] r_retry;
   logic [TW-1:0] r_timer;
   logic [1:0]    w_code;
   logic          w_ack, w_nack, w_bat_ok, w_bat_bad, w_start;
   assign w_ack       = received_data_en && received_data == 8'hFA;
   assign w_nack      = received_data_en && received_data == 8'hFE;
   assign w_bat_ok    = received_data_en && received_data == 8'hAA;
   assign w_bat_bad   = received_data_en && received_data == 8'hFC;
   assign w_start     = r_state == IDLE && w_next == SEND;
   assign the_command = r_state != SEND ? 8'h00 : r_is_rst ? 8'hFF : r_idx ? {5'b0, r_snap} : 8'hED;
   assign send_command = r_state == SEND;
   assign rx_filter   = r_state == WAIT_ACK || r_state == WAIT_BAT;
   assign busy        = r_state != IDLE;
   assign done        = r_state == DONE;
   assign err         = r_state == FAIL;
   // A recognised response byte takes priority over a timer expiry on the same cycle.
   always_comb begin
      w_next = r_state;
      w_code = err_code;
      case (r_state)
         IDLE: begin
            w_next = (r_rst_pend || r_led_pend) ? SEND : IDLE;
            w_code = (r_rst_pend || r_led_pend) ? 2'd0 : err_code;
         end
         SEND: begin
            w_next = command_was_sent ? WAIT_ACK : error_communication_timed_out ? FAIL : SEND;
            w_code = (!command_was_sent && error_communication_timed_out) ? 2'd1 : err_code;
         end
         WAIT_ACK: begin
            if (w_ack) w_next = r_is_rst ? WAIT_BAT : r_idx ? DONE : SEND;
            else if (w_nack) begin
               w_next = r_retry < RETRY_MAX ? SEND : FAIL;
               w_code = r_retry < RETRY_MAX ? err_code : 2'd3;
            end else if (r_timer == ACK_LAST) begin
               w_next = FAIL;
               w_code = 2'd2;
            end
         end
         WAIT_BAT: begin
            if (w_bat_ok) w_next = DONE;
            else if (w_bat_bad || r_timer == BAT_LAST) begin
               w_next = FAIL;
               w_code = w_bat_bad ? 2'd3 : 2'd2;
            end
         end
         default: w_next = IDLE;
      endcase
   end
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         r_state      <= IDLE;
         r_led_pend   <= 1'b0;
         r_rst_pend   <= 1'b0;
         r_is_rst     <= 1'b0;
         r_idx        <= 1'b0;
         r_led_bits   <= 3'b0;
         r_snap       <= 3'b0;
         r_retry      <= '0;
         r_timer      <= '0;
         err_code     <= 2'd0;
         leds_applied <= 3'b0;
      end else begin
         r_state  <= w_next;
         err_code <= w_code;
         // timer runs only while parked in a wait state; any state change restarts it
         r_timer  <= (w_next == r_state && rx_filter) ? r_timer + 1'b1 : '0;
         if (w_start) begin
            r_is_rst <= r_rst_pend;
            r_snap   <= r_led_bits;
            r_idx    <= 1'b0;
            r_retry  <= '0;
         end
         if (r_state == WAIT_ACK && w_ack) begin
            r_idx   <= 1'b1;
            r_retry <= '0;
         end
         if (r_state == WAIT_ACK && w_nack) r_retry <= r_retry + 1'b1;
         if (w_next == DONE) leds_applied <= r_is_rst ? 3'b0 : r_snap;
         // a request arriving on the cycle its pend is consumed stays pending
         r_rst_pend <= kbd_rst_req || (r_rst_pend && !w_start);
         r_led_pend <= led_req || (r_led_pend && !(w_start && !r_rst_pend));
         if (led_req) r_led_bits <= led_bits;
      end
   end
endmodule

// File: tb/tb_ps2_kbd_cmd_sequencer.sv
// tb_ps2_kbd_cmd_sequencer: scoreboard bench with a keyboard/transmitter responder and a command-level reference model
module tb_ps2_kbd_cmd_sequencer;
   localparam int ACK_TO = 100;
   localparam int BAT_TO = 300;
   localparam int MAX_RETRY = 3;
   logic       CLOCK_50 = 1'b0;
   logic       reset = 1'b1;
   logic       led_req = 1'b0;
   logic [2:0] led_bits = 3'b0;
   logic       kbd_rst_req = 1'b0;
   logic [7:0] received_data = 8'h00;
   logic       received_data_en = 1'b0;
   logic       command_was_sent = 1'b0;
   logic       error_communication_timed_out = 1'b0;
   logic [7:0] the_command;
   logic       send_command, rx_filter, busy, done, err;
   logic [1:0] err_code;
   logic [2:0] leds_applied;
   always #5 CLOCK_50 = ~CLOCK_50;
   ps2_kbd_cmd_sequencer #(.ACK_TIMEOUT(ACK_TO), .BAT_TIMEOUT(BAT_TO), .MAX_RETRY(MAX_RETRY)) dut (
      .CLOCK_50(CLOCK_50), .reset(reset), .led_req(led_req), .led_bits(led_bits),
      .kbd_rst_req(kbd_rst_req), .received_data(received_data), .received_data_en(received_data_en),
      .command_was_sent(command_was_sent), .error_communication_timed_out(error_communication_timed_out),
      .the_command(the_command), .send_command(send_command), .rx_filter(rx_filter), .busy(busy),
      .done(done), .err(err), .err_code(err_code), .leds_applied(leds_applied)
   );
   // kind: 0 = byte transmitted, 1 = done (val = leds_applied), 2 = err (val = err_code); run = required WAIT_ACK length or -1
   typedef struct { int kind; int val; int run; } ev_t;
   typedef struct { bit line_ok; bit junk; logic [7:0] junk_v; bit has_resp; logic [7:0] resp; bit has_bat; logic [7:0] bat; } act_t;
   ev_t  sb[$];
   act_t aq[$];
   int   n_chk = 0, n_pass = 0;
   logic [2:0] m_leds = 3'b0;
   logic [1:0] m_code = 2'd0;
   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask
   // Reference model: walks the command's bytes, applying the ACK/resend/BAT rules to the planned keyboard behaviour.
   task automatic plan_cmd(input bit is_rst, input logic [2:0] bits, input int lf_idx, input int nfe0,
                           input int nfe1, input int sil_idx, input int bat, input bit junk);
      logic [7:0] bytes [2];
      int nb;
      nb = is_rst ? 1 : 2;
      bytes[0] = is_rst ? 8'hFF : 8'hED;
      bytes[1] = {5'b0, bits};
      for (int i = 0; i < nb; i++) begin
         for (int a = 0; a < 16; a++) begin
            act_t x;
            x.line_ok = 1'b1; x.junk = junk; x.junk_v = 8'h20 + 8'($urandom_range(0, 63));
            x.has_resp = 1'b0; x.resp = 8'h00; x.has_bat = 1'b0; x.bat = 8'h00;
            sb.push_back('{0, int'(bytes[i]), -1});
            if (i == lf_idx && a == 0) begin
               x.line_ok = 1'b0; aq.push_back(x);
               sb.push_back('{2, 1, -1}); m_code = 2'd1; return;
            end
            if (a < (i == 0 ? nfe0 : nfe1)) begin
               x.has_resp = 1'b1; x.resp = 8'hFE; aq.push_back(x);
               if (a == MAX_RETRY) begin sb.push_back('{2, 3, -1}); m_code = 2'd3; return; end
            end else if (i == sil_idx) begin
               aq.push_back(x);
               sb.push_back('{2, 2, ACK_TO}); m_code = 2'd2; return;
            end else begin
               x.has_resp = 1'b1; x.resp = 8'hFA;
               x.has_bat = is_rst && bat != 2; x.bat = bat == 0 ? 8'hAA : 8'hFC;
               aq.push_back(x);
               break;
            end
         end
      end
      if (is_rst && bat != 0) begin
         sb.push_back('{2, bat == 1 ? 3 : 2, -1}); m_code = bat == 1 ? 2'd3 : 2'd2; return;
      end
      m_leds = is_rst ? 3'b0 : bits;
      m_code = 2'd0;
      sb.push_back('{1, int'(m_leds), -1});
   endtask
   task automatic rx_pulse(input logic [7:0] v);
      received_data = v; received_data_en = 1'b1;
      #1 chk("rx_filter_on_rx", rx_filter, 1);
      @(negedge CLOCK_50);
      received_data_en = 1'b0;
   endtask
   // Transmitter + keyboard responder: one planned action per transmission.
   initial begin : kbd
      act_t x;
      forever begin
         @(negedge CLOCK_50);
         if (send_command) begin
            if (aq.size() != 0) x = aq.pop_front();
            else begin
               x.line_ok = 1'b1; x.junk = 1'b0; x.has_resp = 1'b0; x.has_bat = 1'b0;
            end
            repeat (2) @(negedge CLOCK_50);
            if (x.line_ok) command_was_sent = 1'b1; else error_communication_timed_out = 1'b1;
            @(negedge CLOCK_50);
            command_was_sent = 1'b0; error_communication_timed_out = 1'b0;
            if (x.line_ok) begin
               repeat (3) @(negedge CLOCK_50);
               if (x.junk) rx_pulse(x.junk_v);
               if (x.has_resp) rx_pulse(x.resp);
               if (x.has_bat) begin repeat (4) @(negedge CLOCK_50); rx_pulse(x.bat); end
            end
         end
      end
   end
   initial begin : mon
      ev_t e;
      int  kind, run, last_run;
      bit  prev_send;
      run = 0; last_run = 0; prev_send = 1'b0;
      forever begin
         @(negedge CLOCK_50);
         if (rx_filter) run++;
         else begin last_run = run; run = 0; end
         kind = (send_command && !prev_send) ? 0 : done ? 1 : err ? 2 : -1;
         prev_send = send_command;
         if (kind >= 0) begin
            if (sb.size() == 0) chk("unexpected_event", kind, -1);
            else begin
               e = sb.pop_front();
               chk("event_kind", kind, e.kind);
               if (kind == e.kind && kind == 0) chk("tx_byte", the_command, e.val);
               if (kind == e.kind && kind == 1) chk("done_leds", leds_applied, e.val);
               if (kind == e.kind && kind == 2) chk("err_code", err_code, e.val);
               if (kind == e.kind && kind == 2 && e.run >= 0) chk("ack_wait_cycles", last_run, e.run);
            end
         end
      end
   end
   task automatic request(input bit l, input bit r, input logic [2:0] b);
      led_req = l; kbd_rst_req = r; led_bits = b;
      @(negedge CLOCK_50);
      led_req = 1'b0; kbd_rst_req = 1'b0;
   endtask
   task automatic wait_idle(input string name);
      int t;
      t = 0;
      while ((sb.size() != 0 || aq.size() != 0 || busy) && t < 6000) begin @(negedge CLOCK_50); t++; end
      repeat (3) @(negedge CLOCK_50);
      chk({name, "_pending_events"}, sb.size(), 0);
      chk({name, "_busy"}, busy, 0);
      chk({name, "_leds_applied"}, leds_applied, m_leds);
      chk({name, "_err_code"}, err_code, m_code);
      sb.delete(); aq.delete();
   endtask
   task automatic one(input string name, input bit is_rst, input logic [2:0] bits, input int lf, input int nfe0,
                      input int nfe1, input int sil, input int bat, input bit junk);
      plan_cmd(is_rst, bits, lf, nfe0, nfe1, sil, bat, junk);
      request(!is_rst, is_rst, bits);
      wait_idle(name);
   endtask
   task automatic plan_rand(input bit is_rst, input logic [2:0] bits, input bit rnd);
      if (!rnd) plan_cmd(is_rst, bits, -1, 0, 0, -1, 0, 1'b0);
      else plan_cmd(is_rst, bits, ($urandom % 8 == 0) ? int'($urandom % 2) : -1,
                    ($urandom % 4 == 0) ? int'($urandom_range(1, 4)) : 0,
                    ($urandom % 4 == 0) ? int'($urandom_range(1, 4)) : 0,
                    ($urandom % 10 == 0) ? int'($urandom % 2) : -1,
                    ($urandom % 6 == 0) ? int'($urandom_range(1, 2)) : 0, 1'($urandom % 2));
   endtask
   // Requests issued together, optionally followed by a led_req while the first command is in flight.
   task automatic run_iter(input string name, input bit rnd, input bit l, input bit r, input logic [2:0] b1,
                           input bit mid, input logic [2:0] b2);
      bit         c_rst[$];
      logic [2:0] c_bits[$];
      if (r) begin c_rst.push_back(1'b1); c_bits.push_back(3'b0); end
      if (l) begin c_rst.push_back(1'b0); c_bits.push_back(b1); end
      if (mid && r && l) c_bits[1] = b2;
      else if (mid) begin c_rst.push_back(1'b0); c_bits.push_back(b2); end
      foreach (c_rst[i]) plan_rand(c_rst[i], c_bits[i], rnd);
      request(l, r, b1);
      if (mid) begin repeat (2) @(negedge CLOCK_50); request(1'b1, 1'b0, b2); end
      wait_idle(name);
   endtask
   initial begin : stim
      int t;
      bit l, r;
      repeat (3) @(negedge CLOCK_50);
      chk("rst_busy", busy, 0);
      chk("rst_send", send_command, 0);
      chk("rst_cmd", the_command, 0);
      chk("rst_filter", rx_filter, 0);
      chk("rst_done_err", {done, err}, 0);
      chk("rst_code_leds", {err_code, leds_applied}, 0);
      reset = 1'b0;
      @(negedge CLOCK_50);
      one("led_100", 1'b0, 3'b100, -1, 0, 0, -1, 0, 1'b0);
      one("kbd_reset", 1'b1, 3'b000, -1, 0, 0, -1, 0, 1'b1);
      one("led_3_resend", 1'b0, 3'b010, -1, 3, 0, -1, 0, 1'b1);
      one("led_4_resend", 1'b0, 3'b001, -1, 4, 0, -1, 0, 1'b0);
      one("led_arg_resend", 1'b0, 3'b111, -1, 0, 2, -1, 0, 1'b0);
      one("ack_timeout", 1'b0, 3'b000, -1, 0, 0, 0, 0, 1'b0);
      one("line_timeout", 1'b0, 3'b110, 0, 0, 0, -1, 0, 1'b0);
      one("arg_timeout_junk", 1'b0, 3'b101, -1, 0, 0, 1, 0, 1'b1);
      one("arg_line_timeout", 1'b0, 3'b011, 1, 0, 0, -1, 0, 1'b0);
      one("bat_fc", 1'b1, 3'b000, -1, 0, 0, -1, 1, 1'b0);
      one("bat_timeout", 1'b1, 3'b000, -1, 0, 0, -1, 2, 1'b0);
      run_iter("both_then_mid", 1'b0, 1'b1, 1'b1, 3'b101, 1'b1, 3'b011);
      run_iter("led_then_led", 1'b0, 1'b1, 1'b0, 3'b100, 1'b1, 3'b011);
      // reset in WAIT_ACK: no done/err, pends gone
      sb.push_back('{0, 8'hED, -1});
      plan_cmd(1'b0, 3'b110, -1, 0, 0, 0, 0, 1'b0);
      sb.delete();
      sb.push_back('{0, 8'hED, -1});
      request(1'b1, 1'b0, 3'b110);
      request(1'b1, 1'b0, 3'b001);
      t = 0;
      while (!rx_filter && t < 50) begin @(negedge CLOCK_50); t++; end
      chk("reached_wait_ack", rx_filter, 1);
      reset = 1'b1;
      @(negedge CLOCK_50);
      chk("midrst_busy", busy, 0);
      chk("midrst_send", send_command, 0);
      chk("midrst_filter", rx_filter, 0);
      reset = 1'b0;
      repeat (2 * ACK_TO) @(negedge CLOCK_50);
      chk("midrst_events", sb.size(), 0);
      chk("midrst_idle", busy, 0);
      chk("midrst_leds", leds_applied, 0);
      m_leds = 3'b0; m_code = 2'd0;
      sb.delete(); aq.delete();
      one("after_reset", 1'b0, 3'b101, -1, 0, 0, -1, 0, 1'b0);
      for (int k = 0; k < 40; k++) begin
         l = 1'($urandom % 2);
         r = l ? 1'($urandom % 3 == 0) : 1'b1;
         run_iter("rand", 1'b1, l, r, 3'($urandom), 1'($urandom % 3 == 0), 3'($urandom));
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
   initial begin : watchdog
      #900000;
      $display("FAIL watchdog: simulation time limit reached with %0d of %0d checks passed", n_pass, n_chk);
      $fatal(1, "time limit");
   end
endmodule
